// File: rtl/microwave_ctrl_param.sv
// Microwave controller: keypad BCD entry, prescaled countdown, cook FSM, power duty.
// Optional QUICK_START_EN: zero-time start loads 00:30 and start presses in COOK add 30 s.
module microwave_ctrl_param #(
    parameter int CLK_DIV      = 50000000,
    parameter int MIN_DIGITS   = 1,
    parameter int POWER_LEVELS = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        startn,
    input  logic                        stopn,
    input  logic                        clearn,
    input  logic                        door_closed,
    input  logic [9:0]                  keypad,
    input  logic [3:0]                  power_sel,
    output logic [4*(MIN_DIGITS+2)-1:0] time_bcd,
    output logic                        mag_on,
    output logic                        cooking,
    output logic                        done
);
    localparam int ND = MIN_DIGITS + 2;
    localparam int TW = 4 * ND;
    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, COOK, PAUSED, DONE} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] time_q, time_d, t_next;
    logic [CW-1:0] presc_q, presc_d;
    logic [7:0]    duty_q, duty_d, pwr_q, pwr_d, pwr_sat;
    logic [9:0]    key_prev_q;
    logic          mag_q, mag_d;
    logic          key_ev, halt, go, tick;
    logic [3:0]    key_digit;

    function automatic logic [TW-1:0] bcd_dec(input logic [TW-1:0] t);
        logic [TW-1:0] r;
        logic          borrow;
        r      = t;
        borrow = 1'b1;
        for (int i = 0; i < ND; i++) begin
            if (borrow) begin
                if (t[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
                end else begin
                    r[4*i +: 4] = t[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

`ifdef QUICK_START_EN
    logic start_prev_q;
    logic start_fall;

    assign start_fall = start_prev_q & ~startn;

    // +30 s with carry into minutes; overflow saturates at all-9:59
    function automatic logic [TW-1:0] add30(input logic [TW-1:0] t);
        logic [TW-1:0] r;
        logic          carry;
        r     = t;
        carry = 1'b0;
        if (t[7:4] >= 4'd3) begin
            r[7:4] = t[7:4] - 4'd3;
            carry  = 1'b1;
        end else begin
            r[7:4] = t[7:4] + 4'd3;
        end
        for (int i = 2; i < ND; i++) begin
            if (carry) begin
                if (t[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = t[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        if (carry) begin
            for (int i = 2; i < ND; i++) r[4*i +: 4] = 4'd9;
            r[7:0] = 8'h59;
        end
        return r;
    endfunction
`endif

    always_comb begin
        key_digit = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (keypad[k]) key_digit = 4'(k);
        end
    end

    assign key_ev  = (key_prev_q == '0) && (keypad != '0)
                     && ((keypad & (keypad - 10'd1)) == '0);
    assign halt    = !stopn || !door_closed;
    assign go      = !startn && door_closed && stopn;
    assign pwr_sat = (power_sel == 4'd0 || {4'd0, power_sel} > 8'(POWER_LEVELS))
                     ? 8'(POWER_LEVELS) : {4'd0, power_sel};

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        presc_d = presc_q;
        duty_d  = duty_q;
        pwr_d   = pwr_q;
        t_next  = time_q;
        tick    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (go && time_q != '0 && time_q[7:4] <= 4'd5) begin
                    state_d = COOK;
                    presc_d = '0;
                    duty_d  = '0;
                    pwr_d   = pwr_sat;
                end
`ifdef QUICK_START_EN
                else if (go && time_q == '0) begin
                    state_d = COOK;
                    time_d  = TW'(8'h30);
                    presc_d = '0;
                    duty_d  = '0;
                    pwr_d   = pwr_sat;
                end
`endif
                else if (key_ev) begin
                    time_d = {time_q[TW-5:0], key_digit};
                end
            end
            COOK: begin
                tick = (presc_q == CW'(CLK_DIV - 1));
                if (tick) t_next = bcd_dec(time_q);
`ifdef QUICK_START_EN
                if (!halt && start_fall) t_next = add30(t_next);
`endif
                time_d = t_next;
                // a tick coinciding with stop is still consumed
                if (tick) begin
                    presc_d = '0;
                    duty_d  = (duty_q == 8'(POWER_LEVELS - 1)) ? 8'd0 : duty_q + 8'd1;
                end else if (!halt) begin
                    presc_d = presc_q + CW'(1);
                end
                if (tick && t_next == '0) state_d = DONE;
                else if (halt)            state_d = PAUSED;
            end
            PAUSED: begin
                if (go) state_d = COOK;
            end
            DONE: begin
                if (key_ev) begin
                    time_d  = TW'(key_digit);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!clearn) begin
            state_d = IDLE;
            time_d  = '0;
            presc_d = '0;
        end
        mag_d = (state_q == COOK) && (state_d == COOK)
                && (duty_d < pwr_d) && door_closed;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            time_q     <= '0;
            presc_q    <= '0;
            duty_q     <= '0;
            pwr_q      <= 8'(POWER_LEVELS);
            key_prev_q <= '0;
            mag_q      <= 1'b0;
`ifdef QUICK_START_EN
            start_prev_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            presc_q    <= presc_d;
            duty_q     <= duty_d;
            pwr_q      <= pwr_d;
            key_prev_q <= keypad;
            mag_q      <= mag_d;
`ifdef QUICK_START_EN
            start_prev_q <= startn;
`endif
        end
    end

    // door interlock gates the magnetron without waiting for a clock
    assign mag_on   = mag_q & door_closed;
    assign time_bcd = time_q;
    assign cooking  = (state_q == COOK);
    assign done     = (state_q == DONE);

endmodule
